// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_pkg
//  Purpose  : Shared opcodes, header field positions and FSM states for the
//             program loader.
//  Revision : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    typedef enum logic [1:0] {
        OP_IMEM = 2'b00,
        OP_REG  = 2'b01,
        OP_DUMP = 2'b10,
        OP_GO   = 2'b11
    } opcode_t;

    localparam int c_opc_msb = 31;
    localparam int c_opc_lsb = 30;
    localparam int c_cnt_msb = 29;
    localparam int c_cnt_lsb = 16;
    localparam int c_arg_msb = 15;
    localparam int c_arg_lsb = 0;
    localparam int c_cnt_w   = c_cnt_msb - c_cnt_lsb + 1;
    localparam int c_arg_w   = c_arg_msb - c_arg_lsb + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RUN      = 3'd2,
        S_DUMP_RD  = 3'd3,
        S_DUMP_OUT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_hdr.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_hdr
//  Purpose  : Splits a command header word into opcode, count and argument.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader_hdr
    import prog_loader_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0]      hdr,
    output opcode_t            opcode,
    output logic [c_cnt_w-1:0] count,
    output logic [c_arg_w-1:0] arg
);

    assign opcode = opcode_t'(hdr[c_opc_msb:c_opc_lsb]);
    assign count  = hdr[c_cnt_msb:c_cnt_lsb];
    assign arg    = hdr[c_arg_msb:c_arg_lsb];

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Command-stream driven loader: fills instruction memory and
//             registers, runs the processor with an optional cycle limit and
//             streams a register dump back out.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int  DW   = 32,
    parameter int  AW   = 10,
    parameter int  NREG = 32,
    localparam int RW   = $clog2(NREG),
    localparam int PW   = (AW > RW) ? AW : RW
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_data,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          reg_we,
    output logic [RW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    output logic [RW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          cpu_run,
    input  logic          cpu_halted,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [DW-1:0] dump_data,
    output logic          dump_last,
    output logic          busy,
    output logic          timeout_flag,
    output logic [15:0]   cycle_count
);

    opcode_t            w_opcode;
    logic [c_cnt_w-1:0] w_count;
    logic [c_arg_w-1:0] w_arg;

    prog_loader_hdr #(.DW(DW)) u_hdr (
        .hdr    (cmd_data),
        .opcode (w_opcode),
        .count  (w_count),
        .arg    (w_arg)
    );

    state_t             r_state,   w_state_nx;
    logic [PW-1:0]      r_ptr,     w_ptr_nx;
    logic [c_cnt_w-1:0] r_rem,     w_rem_nx;
    logic               r_is_reg,  w_is_reg_nx;
    logic [15:0]        r_limit,   w_limit_nx;
    logic [15:0]        r_cycle,   w_cycle_nx;
    logic               r_timeout, w_timeout_nx;
    logic               r_have,    w_have_nx;
    logic [DW-1:0]      r_dbuf,    w_dbuf_nx;

    logic        w_fire;
    logic        w_wr;
    logic [15:0] w_cyc_inc;

    // Reset gates every strobe so an aborted transfer never leaks a pulse.
    assign cmd_ready = !rst && ((r_state == S_IDLE) || (r_state == S_WRITE));
    assign w_fire    = cmd_valid && cmd_ready;
    assign w_wr      = w_fire && (r_state == S_WRITE);
    assign w_cyc_inc = (r_cycle == 16'hFFFF) ? r_cycle : r_cycle + 16'd1;

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_rem_nx     = r_rem;
        w_is_reg_nx  = r_is_reg;
        w_limit_nx   = r_limit;
        w_cycle_nx   = r_cycle;
        w_timeout_nx = r_timeout;
        w_have_nx    = r_have;
        w_dbuf_nx    = r_dbuf;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    case (w_opcode)
                        OP_IMEM, OP_REG: begin
                            if (w_count != '0) begin
                                w_state_nx  = S_WRITE;
                                w_ptr_nx    = w_arg[PW-1:0];
                                w_rem_nx    = w_count;
                                w_is_reg_nx = (w_opcode == OP_REG);
                            end
                        end
                        OP_DUMP: begin
                            if (w_count != '0) begin
                                w_state_nx = S_DUMP_RD;
                                w_ptr_nx   = w_arg[PW-1:0];
                                w_rem_nx   = w_count;
                            end
                        end
                        OP_GO: begin
                            w_state_nx   = S_RUN;
                            w_cycle_nx   = 16'd0;
                            w_timeout_nx = 1'b0;
                            w_limit_nx   = w_arg;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                if (w_fire) begin
                    w_ptr_nx = r_ptr + PW'(1);
                    w_rem_nx = r_rem - 14'd1;
                    if (r_rem == 14'd1) begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                w_cycle_nx = w_cyc_inc;
                if (cpu_halted) begin
                    w_state_nx = S_IDLE;
                end else if ((r_limit != 16'd0) && (w_cyc_inc == r_limit)) begin
                    w_state_nx   = S_IDLE;
                    w_timeout_nx = 1'b1;
                end
            end
            S_DUMP_RD: begin
                w_state_nx = S_DUMP_OUT;
                w_have_nx  = 1'b0;
            end
            S_DUMP_OUT: begin
                // rd_addr returns to 0 here, so the read word is captured to ride out a stall.
                if (!r_have) begin
                    w_dbuf_nx = rd_data;
                    w_have_nx = 1'b1;
                end
                if (dump_ready) begin
                    w_have_nx  = 1'b0;
                    w_ptr_nx   = r_ptr + PW'(1);
                    w_rem_nx   = r_rem - 14'd1;
                    w_state_nx = (r_rem == 14'd1) ? S_IDLE : S_DUMP_RD;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_rem     <= '0;
            r_is_reg  <= 1'b0;
            r_limit   <= '0;
            r_cycle   <= '0;
            r_timeout <= 1'b0;
            r_have    <= 1'b0;
            r_dbuf    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_rem     <= w_rem_nx;
            r_is_reg  <= w_is_reg_nx;
            r_limit   <= w_limit_nx;
            r_cycle   <= w_cycle_nx;
            r_timeout <= w_timeout_nx;
            r_have    <= w_have_nx;
            r_dbuf    <= w_dbuf_nx;
        end
    end

    assign imem_we    = w_wr && !r_is_reg;
    assign reg_we     = w_wr && r_is_reg;
    assign imem_addr  = imem_we ? r_ptr[AW-1:0] : '0;
    assign imem_wdata = imem_we ? cmd_data : '0;
    assign reg_addr   = reg_we ? r_ptr[RW-1:0] : '0;
    assign reg_wdata  = reg_we ? cmd_data : '0;

    assign rd_addr    = (r_state == S_DUMP_RD) ? r_ptr[RW-1:0] : '0;
    assign dump_valid = !rst && (r_state == S_DUMP_OUT);
    assign dump_last  = dump_valid && (r_rem == 14'd1);
    assign dump_data  = dump_valid ? (r_have ? r_dbuf : rd_data) : '0;

    assign cpu_run      = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE);
    assign timeout_flag = r_timeout;
    assign cycle_count  = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed self-checking bench for prog_loader with a queue-based
//             reference model checked on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int NREG = 32;
    localparam int RW   = 5;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          reg_we;
    logic [RW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [RW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          cpu_run;
    logic          cpu_halted = 1'b0;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          busy;
    logic          timeout_flag;
    logic [15:0]   cycle_count;

    always #5 clk1 = ~clk1;

    prog_loader #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk1(clk1), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last),
        .busy(busy), .timeout_flag(timeout_flag), .cycle_count(cycle_count)
    );

    // Register file contents seen by the dump path: word at address a is a*10.
    always @(posedge clk1) rd_data <= 32'(rd_addr) * 32'd10;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] data; logic last; } dw_t;

    wr_t         exp_imem[$];
    wr_t         exp_reg[$];
    wr_t         got_reg[$];
    dw_t         exp_dump[$];
    logic [31:0] got_dump[$];
    logic [31:0] payload[12];
    int          n_imem = 0;
    int          n_reg  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every observable transfer against the model queues.
    always @(negedge clk1) begin
        wr_t e;
        dw_t d;
        if (!rst) begin
            check("exclusive_strobes",
                  32'($countones({imem_we, reg_we, cpu_run, dump_valid}) <= 1), 32'd1);
        end
        if (imem_we) begin
            n_imem++;
            if (exp_imem.size() == 0) check("imem_unexpected_write", 32'd1, 32'd0);
            else begin
                e = exp_imem.pop_front();
                check("imem_addr", 32'(imem_addr), e.addr);
                check("imem_wdata", imem_wdata, e.data);
            end
        end
        if (reg_we) begin
            n_reg++;
            got_reg.push_back('{addr: 32'(reg_addr), data: reg_wdata});
            if (exp_reg.size() == 0) check("reg_unexpected_write", 32'd1, 32'd0);
            else begin
                e = exp_reg.pop_front();
                check("reg_addr", 32'(reg_addr), e.addr);
                check("reg_wdata", reg_wdata, e.data);
            end
        end
        if (dump_valid) begin
            if (exp_dump.size() == 0) check("dump_unexpected_word", 32'd1, 32'd0);
            else begin
                d = exp_dump[0];
                check("dump_data", dump_data, d.data);
                check("dump_last", 32'(dump_last), 32'(d.last));
                if (dump_ready) begin
                    void'(exp_dump.pop_front());
                    got_dump.push_back(dump_data);
                end
            end
        end
    end

    function automatic logic [31:0] hdr(input logic [1:0] op, input int n, input int arg);
        return {op, n[13:0], arg[15:0]};
    endfunction

    task automatic send(input logic [31:0] w);
        int t;
        cmd_valid = 1'b1;
        cmd_data  = w;
        t = 0;
        @(negedge clk1);
        while (!cmd_ready && t < 50) begin
            @(negedge clk1);
            t++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk1); #1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    // Queues the expected writes for the words actually sent, then sends them.
    task automatic load(input logic [1:0] op, input int n, input int arg, input int nsend);
        for (int i = 0; i < nsend; i++) begin
            if (op == 2'b00) exp_imem.push_back('{addr: 32'((arg + i) % (1 << AW)), data: payload[i]});
            else             exp_reg.push_back('{addr: 32'((arg + i) % NREG), data: payload[i]});
        end
        send(hdr(op, n, arg));
        for (int i = 0; i < nsend; i++) send(payload[i]);
    endtask

    task automatic run_go(input int limit, input int halt_at, input string tag);
        int   n;
        int   exp_n;
        logic exp_to;
        logic to_first;
        if (halt_at != 0 && (limit == 0 || halt_at <= limit)) begin
            exp_n  = halt_at;
            exp_to = 1'b0;
        end else begin
            exp_n  = limit;
            exp_to = 1'b1;
        end
        send(hdr(2'b11, 9, limit));
        n = 0;
        to_first = 1'b1;
        while (cpu_run && n < 400) begin
            n++;
            if (n == 1) to_first = timeout_flag;
            cpu_halted = (n == halt_at);
            @(posedge clk1); #1;
        end
        cpu_halted = 1'b0;
        check({tag, "_run_cycles"}, 32'(n), 32'(exp_n));
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'(exp_n));
        check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'(exp_to));
        check({tag, "_timeout_cleared_on_go"}, 32'(to_first), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic dump(input int n, input int arg, input int stall_idx, input int stall_len);
        int t;
        for (int i = 0; i < n; i++)
            exp_dump.push_back('{data: 32'(((arg + i) % NREG) * 10), last: (i == n - 1)});
        send(hdr(2'b10, n, arg));
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!dump_valid && t < 20) begin
                @(posedge clk1); #1;
                t++;
            end
            if (!dump_valid) check("dump_valid_timeout", 32'd0, 32'd1);
            if (i == stall_idx) repeat (stall_len) begin @(posedge clk1); #1; end
            dump_ready = 1'b1;
            @(posedge clk1); #1;
            dump_ready = 1'b0;
        end
        check("dump_queue_drained", 32'(exp_dump.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_strobes"}, 32'({imem_we, reg_we, cpu_run, dump_valid, dump_last}), 32'd0);
        check({tag, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
        check({tag, "_addrs"}, 32'({imem_addr, reg_addr, rd_addr}), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_reg_wdata"}, reg_wdata, 32'd0);
        check({tag, "_dump_data"}, dump_data, 32'd0);
    endtask

    initial begin
        int base;
        payload = '{32'h84200005, 32'h8440000F, 32'h8C620001, 32'h00A21820,
                    32'h10400003, 32'h20630001, 32'hAC030000, 32'h8C040004,
                    32'h00832022, 32'h1480FFFB, 32'hAC040008, 32'hFC000000};
        repeat (3) @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);
        check_reset_values("reset");
        @(posedge clk1); #1;

        // Zero-length load is a no-op.
        send(hdr(2'b00, 0, 5));
        @(negedge clk1);
        check("n0_busy", 32'(busy), 32'd0);
        check("n0_cmd_ready", 32'(cmd_ready), 32'd1);
        check("n0_no_write", 32'(n_imem), 32'd0);
        @(posedge clk1); #1;

        load(2'b00, 12, 0, 12);
        check("imem_write_count", 32'(n_imem), 32'd12);
        check("imem_queue_drained", 32'(exp_imem.size()), 32'd0);
        check("imem_busy_after", 32'(busy), 32'd0);

        payload[0] = 32'd5;
        payload[1] = 32'd7;
        load(2'b01, 2, 31, 2);
        check("reg_write_count", 32'(n_reg), 32'd2);
        check("reg_first_addr", got_reg[0].addr, 32'd31);
        check("reg_wrap_addr", got_reg[1].addr, 32'd0);
        check("reg_second_data", got_reg[1].data, 32'd7);

        run_go(0, 40, "halt40");
        check("halt40_literal", 32'(cycle_count), 32'd40);
        run_go(100, 0, "limit100");
        check("limit100_literal", 32'(timeout_flag), 32'd1);
        run_go(0, 3, "clear_to");
        run_go(50, 50, "halt_wins");

        dump(3, 1, 1, 5);
        check("dump_count", 32'(got_dump.size()), 32'd3);
        check("dump_word0", got_dump[0], 32'd10);
        check("dump_word1", got_dump[1], 32'd20);
        check("dump_word2", got_dump[2], 32'd30);

        payload[0] = 32'h84200005;
        payload[1] = 32'h8440000F;
        base = n_imem;
        load(2'b00, 12, 0, 4);
        cmd_valid = 1'b1;
        cmd_data  = payload[4];
        rst       = 1'b1;
        @(posedge clk1); #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        @(negedge clk1);
        check("abort_write_count", 32'(n_imem - base), 32'd4);
        check_reset_values("abort");

        check("final_queues_empty", 32'(exp_imem.size() + exp_reg.size() + exp_dump.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DW, default 32: command, memory, register and dump word width.
REQ-002 Parameter AW, default 10: instruction-memory address width.
REQ-003 Parameter NREG, default 32: register count; power of 2; RW = log2(NREG).
REQ-004 clk1  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command stream handshake; a word transfers when both are high.
REQ-007 cmd_data  in  DW  command stream word (header or payload).
REQ-008 imem_we / imem_addr / imem_wdata  out  1 / AW / DW  instruction-memory write port.
REQ-009 reg_we / reg_addr / reg_wdata  out  1 / RW / DW  register-file write port.
REQ-010 rd_addr / rd_data  out / in  RW / DW  register-file read port; rd_data valid one cycle after rd_addr.
REQ-011 cpu_run / cpu_halted  out / in  1 / 1  processor enable; processor halt indication.
REQ-012 dump_valid / dump_ready / dump_data / dump_last  out / in / out / out  1 / 1 / DW / 1  register dump stream.
REQ-013 busy / timeout_flag / cycle_count  out  1 / 1 / 16  status: not IDLE; last run timed out; cycles of last run.

Function
REQ-014 Header word fields: [31:30] opcode, [29:16] count N, [15:0] arg; opcodes 00 IMEM, 01 REG, 10 DUMP, 11 GO.
REQ-015 States: IDLE, WRITE, RUN, DUMP_RD, DUMP_OUT; cmd_ready = 1 only in IDLE and WRITE.
REQ-016 IDLE: accepted header with IMEM/REG and N>0 -> WRITE, pointer = arg, remaining = N; N = 0 -> stays IDLE, no write.
REQ-017 WRITE: each accepted payload word produces one write pulse on the same edge it is accepted (imem_we or reg_we high for exactly that cycle); pointer +1; last word -> IDLE.
REQ-018 Pointer wrap: imem address modulo 2^AW; register address modulo NREG (arg low RW bits used).
REQ-019 GO: accepted -> RUN next cycle; cycle_count cleared; timeout_flag cleared; limit = arg (0 = no limit); N ignored.
REQ-020 RUN: cpu_run = 1; cycle_count +1 per cycle, saturating at 0xFFFF.
REQ-021 RUN exit: cpu_halted = 1 -> IDLE; else cycle_count+1 == limit (limit != 0) -> IDLE, timeout_flag = 1; cpu_run low on the first IDLE cycle.
REQ-022 Halt and limit in the same cycle: halt wins; timeout_flag stays 0.
REQ-023 DUMP with N>0: DUMP_RD drives rd_addr = pointer -> DUMP_OUT presents rd_data with dump_valid = 1, held stable until dump_ready; then pointer +1 -> DUMP_RD, or IDLE after word N; N = 0 -> stays IDLE.
REQ-024 dump_last = 1 with the Nth dump word only; dump_data is not changed while dump_valid = 1 and dump_ready = 0.
REQ-025 Write strobes, cpu_run and dump_valid are never high outside their own states.

Reset
REQ-026 rst: state IDLE; cmd_ready 1 (the first cycle after release); imem_we, reg_we, cpu_run, dump_valid, dump_last, busy, timeout_flag 0; cycle_count 0; all address/data outputs 0.
REQ-027 rst mid-WRITE/RUN/DUMP aborts immediately; no further write pulse; cpu_run drops the next cycle; partial dump is not resumed.

Structure
REQ-028 Package prog_loader_pkg holds opcode constants, header field positions and the state enumeration.
REQ-029 One sub-module, prog_loader_hdr, decodes the header into opcode/count/arg; the rest lives in prog_loader.

Verification
REQ-030 IMEM header N=12 arg=0, then words 84200005, 8440000F, ..., FC000000 -> 12 imem_we pulses, addresses 0..11, data matching in order.
REQ-031 REG header N=2 arg=31 (NREG=32), data 5, 7 -> reg writes at addr 31 then 0 (wrap).
REQ-032 GO arg=0, cpu_halted raised on the 40th RUN cycle -> cpu_run high 40 cycles, cycle_count=40, timeout_flag=0.
REQ-033 GO arg=100, cpu_halted never set -> RUN exits after 100 cycles, timeout_flag=1; next GO clears it.
REQ-034 DUMP N=3 arg=1 with rd_data = addr*10, dump_ready held low 5 cycles on word 2 -> 10, 20, 30 delivered, word 20 held stable throughout stall, dump_last only on 30.
REQ-035 rst asserted mid-WRITE after 4 of 12 payload words -> only 4 writes, state IDLE, all outputs at reset values.
